// File: rtl/score_pkg.sv
// Shared types, geometry constants and helpers for the Pong score renderer.
// Glyphs are 11x16 seven-segment style digits with 2-pixel strokes.
package score_pkg;

  localparam int DIGIT_W      = 11;
  localparam int DIGIT_H      = 16;
  localparam int GLYPH_WORDS  = 176;
  localparam int GLYPH_DIGITS = 10;
  localparam int ROM_WORDS    = GLYPH_WORDS * GLYPH_DIGITS;
  localparam int ROM_AW       = 11;

  localparam logic [2:0] GLYPH_COLOR = 3'b111;

  typedef logic [7:0] bcd2_t;

  typedef enum logic [2:0] {
    SLOT_NONE,
    SLOT_LT,
    SLOT_LU,
    SLOT_RT,
    SLOT_RU
  } slot_e;

  function automatic bcd2_t bcd_inc(input bcd2_t v);
    bcd2_t r;
    if (v == 8'h99)
      r = v;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Segment bits are {a,b,c,d,e,f,g}; f/b and e/c overlap on rows 7-8.
  function automatic logic glyph_pixel(input int digit, input int lrow, input int lcol);
    logic [6:0] seg;
    logic       left;
    logic       right;
    logic       top_half;
    logic       bot_half;
    case (digit)
      0:       seg = 7'b1111110;
      1:       seg = 7'b0110000;
      2:       seg = 7'b1101101;
      3:       seg = 7'b1111001;
      4:       seg = 7'b0110011;
      5:       seg = 7'b1011011;
      6:       seg = 7'b1011111;
      7:       seg = 7'b1110000;
      8:       seg = 7'b1111111;
      9:       seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
    left     = (lcol <= 1);
    right    = (lcol >= DIGIT_W - 2);
    top_half = (lrow <= 8);
    bot_half = (lrow >= 7);
    return (seg[6] && lrow <= 1) ||
           (seg[5] && right && top_half) ||
           (seg[4] && right && bot_half) ||
           (seg[3] && lrow >= DIGIT_H - 2) ||
           (seg[2] && left && bot_half) ||
           (seg[1] && left && top_half) ||
           (seg[0] && (lrow == 7 || lrow == 8));
  endfunction

endpackage

// File: rtl/digit_glyph_rom.sv
// Glyph memory for digits 0-9, 176 words per digit, row-major 11 words per row.
// Contents are elaborated from the package stroke description; read is registered.
module digit_glyph_rom
  import score_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ROM_AW-1:0] addr,
  output logic [2:0]        data
);

  logic [2:0] mem [ROM_WORDS];

  for (genvar a = 0; a < ROM_WORDS; a++) begin : g_word
    assign mem[a] = glyph_pixel(a / GLYPH_WORDS, (a % GLYPH_WORDS) / DIGIT_W, a % DIGIT_W)
                    ? GLYPH_COLOR : 3'b000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      data <= '0;
    else if (int'(addr) < ROM_WORDS)
      data <= mem[addr];
    else
      data <= '0;
  end

endmodule

// File: rtl/score_renderer.sv
// Pong score keeper (2-digit BCD per player) and 11x16 digit renderer, 2-clk pixel latency.
// Optional SCORE_BLINK_EN macro: the winner's digits blink after game over.
module score_renderer
  import score_pkg::*;
#(
  parameter int unsigned ORIGIN_ROW   = 40,
  parameter int unsigned ORIGIN_COL_L = 240,
  parameter int unsigned ORIGIN_COL_R = 360,
  parameter int unsigned DIGIT_GAP    = 2,
  parameter bcd2_t       WIN_SCORE    = 8'h11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       point_l,
  input  logic       point_r,
  input  logic       clear_scores,
  input  logic [9:0] row,
  input  logic [9:0] col,
  output logic [2:0] rgb,
  output bcd2_t      score_l,
  output bcd2_t      score_r,
  output logic       game_over,
  output logic       winner
);

  localparam logic [9:0] ROW_TOP = 10'(ORIGIN_ROW);
  localparam logic [9:0] ROW_END = 10'(ORIGIN_ROW + DIGIT_H);
  localparam logic [9:0] COL_LT  = 10'(ORIGIN_COL_L);
  localparam logic [9:0] COL_LU  = 10'(ORIGIN_COL_L + DIGIT_W + DIGIT_GAP);
  localparam logic [9:0] COL_RT  = 10'(ORIGIN_COL_R);
  localparam logic [9:0] COL_RU  = 10'(ORIGIN_COL_R + DIGIT_W + DIGIT_GAP);
  localparam logic [9:0] W10     = 10'(DIGIT_W);

  localparam logic [ROM_AW-1:0] WORDS_A = ROM_AW'(GLYPH_WORDS);
  localparam logic [ROM_AW-1:0] W_A     = ROM_AW'(DIGIT_W);

  logic pend_l;
  logic pend_r;
  logic take_l;
  logic take_r;
  logic blank_l;
  logic blank_r;

  assign take_l = pend_l | point_l;
  assign take_r = pend_r | point_r;

  // Points are queued and only committed on frame_start so a frame never shows a torn score.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_l   <= '0;
      score_r   <= '0;
      pend_l    <= 1'b0;
      pend_r    <= 1'b0;
      game_over <= 1'b0;
      winner    <= 1'b0;
    end else if (clear_scores) begin
      score_l   <= '0;
      score_r   <= '0;
      pend_l    <= 1'b0;
      pend_r    <= 1'b0;
      game_over <= 1'b0;
      winner    <= 1'b0;
    end else if (game_over) begin
      pend_l <= 1'b0;
      pend_r <= 1'b0;
    end else begin
      if (frame_start) begin
        if (take_l) score_l <= bcd_inc(score_l);
        if (take_r) score_r <= bcd_inc(score_r);
        pend_l <= 1'b0;
        pend_r <= 1'b0;
      end else begin
        pend_l <= take_l;
        pend_r <= take_r;
      end
      if (score_l == WIN_SCORE || score_r == WIN_SCORE) begin
        game_over <= 1'b1;
        winner    <= (score_l != WIN_SCORE);
      end
    end
  end

`ifdef SCORE_BLINK_EN
  logic [4:0] frame_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      frame_cnt <= '0;
    else if (clear_scores)
      frame_cnt <= '0;
    else if (frame_start)
      frame_cnt <= frame_cnt + 5'd1;
  end

  assign blank_l = game_over && !winner && frame_cnt[4];
  assign blank_r = game_over &&  winner && frame_cnt[4];
`else
  assign blank_l = 1'b0;
  assign blank_r = 1'b0;
`endif

  slot_e      slot;
  logic       in_rows;
  logic [9:0] base_col;
  logic [3:0] digit_val;
  logic       hit_next;
  logic [3:0] lrow_next;
  logic [3:0] lcol_next;

  // S1 decode: tens slots with a zero digit are blanked (no leading zero).
  always_comb begin
    slot      = SLOT_NONE;
    base_col  = '0;
    digit_val = '0;
    hit_next  = 1'b0;
    in_rows   = (row >= ROW_TOP) && (row < ROW_END);
    if (in_rows) begin
      if (col >= COL_LT && col < COL_LT + W10)
        slot = SLOT_LT;
      else if (col >= COL_LU && col < COL_LU + W10)
        slot = SLOT_LU;
      else if (col >= COL_RT && col < COL_RT + W10)
        slot = SLOT_RT;
      else if (col >= COL_RU && col < COL_RU + W10)
        slot = SLOT_RU;
    end
    case (slot)
      SLOT_LT: begin
        base_col  = COL_LT;
        digit_val = score_l[7:4];
        hit_next  = (score_l[7:4] != 4'd0) && !blank_l;
      end
      SLOT_LU: begin
        base_col  = COL_LU;
        digit_val = score_l[3:0];
        hit_next  = !blank_l;
      end
      SLOT_RT: begin
        base_col  = COL_RT;
        digit_val = score_r[7:4];
        hit_next  = (score_r[7:4] != 4'd0) && !blank_r;
      end
      SLOT_RU: begin
        base_col  = COL_RU;
        digit_val = score_r[3:0];
        hit_next  = !blank_r;
      end
      default: ;
    endcase
    lrow_next = 4'(row - ROW_TOP);
    lcol_next = 4'(col - base_col);
  end

  logic       hit_s1;
  logic [3:0] digit_s1;
  logic [3:0] lrow_s1;
  logic [3:0] lcol_s1;
  logic       hit_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_s1   <= 1'b0;
      digit_s1 <= '0;
      lrow_s1  <= '0;
      lcol_s1  <= '0;
      hit_s2   <= 1'b0;
    end else begin
      hit_s1   <= hit_next;
      digit_s1 <= digit_val;
      lrow_s1  <= lrow_next;
      lcol_s1  <= lcol_next;
      hit_s2   <= hit_s1;
    end
  end

  logic [ROM_AW-1:0] glyph_addr;
  logic [2:0]        rom_data;

  assign glyph_addr = ROM_AW'(digit_s1) * WORDS_A + ROM_AW'(lrow_s1) * W_A + ROM_AW'(lcol_s1);

  digit_glyph_rom u_rom (
    .clk   (clk),
    .reset (reset),
    .addr  (glyph_addr),
    .data  (rom_data)
  );

  assign rgb = hit_s2 ? rom_data : 3'b000;

endmodule
